// File: rtl/audio_fx_pkg.sv
// Shared definitions for the audio gate effect.
// Holds the gate mode encodings and the handshake FSM state type.
// No ports: this file is a package only.
package audio_fx_pkg;

    localparam logic [1:0] MODE_BYPASS  = 2'd0;
    localparam logic [1:0] MODE_GATE    = 2'd1;
    localparam logic [1:0] MODE_ATTEN   = 2'd2;
    localparam logic [1:0] MODE_INVGATE = 2'd3;

    typedef enum logic [1:0] {
        st_idle,
        st_read,
        st_proc,
        st_write
    } state_t;

endpackage

// File: rtl/audio_gate_fx_gate_divider.sv
// Gate phase generator: a half-period counter that toggles gate_phase on wrap.
// Ports:
//   clk, rst    - clock and asynchronous active-high reset
//   cfg_period  - half-period in clocks minus 1; 0 disables the gate
//   gate_phase  - registered gate phase (forced 0 while disabled)
module gate_divider #(
    parameter int DIV_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] cfg_period,
    output logic             gate_phase
);

    logic [DIV_W-1:0] count_q, count_d;
    logic             phase_q, phase_d;

    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (cfg_period == '0) begin
            count_d = '0;
            phase_d = 1'b0;
        end else if (count_q >= cfg_period) begin
            // >= so that lowering the period below the current count wraps at once
            count_d = '0;
            phase_d = ~phase_q;
        end else begin
            count_d = count_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            phase_q <= 1'b0;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign gate_phase = phase_q;

endmodule

// File: rtl/audio_gate_fx.sv
// Audio chopper/gate between the input FIFO and the output FIFO.
// A registered IDLE->READ->PROC->WRITE handshake pops one sample set, applies
// the gate mode captured at READ to every channel, and pushes the result while
// publishing a peak-level meter value.
// Ports:
//   CLOCK_50, reset                  - clock, asynchronous active-high reset
//   cfg_period, cfg_mode             - gate half-period (minus 1) and gate mode
//   audio_in_available/_data         - input FIFO status and sample set
//   read_audio_in                    - one-cycle pop strobe
//   audio_out_allowed                - output FIFO has space
//   audio_out_data, write_audio_out  - processed sample set and push strobe
//   gate_phase                       - current gate phase
//   meter_level, meter_valid         - peak |sample| of last written set, update pulse
module audio_gate_fx #(
    parameter int DATA_W      = 32,
    parameter int CHANNELS    = 2,
    parameter int DIV_W       = 18,
    parameter int ATTEN_SHIFT = 2,
    parameter int METER_W     = 16
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [DIV_W-1:0]           cfg_period,
    input  logic [1:0]                 cfg_mode,
    input  logic                       audio_in_available,
    input  logic [CHANNELS*DATA_W-1:0] audio_in_data,
    output logic                       read_audio_in,
    input  logic                       audio_out_allowed,
    output logic [CHANNELS*DATA_W-1:0] audio_out_data,
    output logic                       write_audio_out,
    output logic                       gate_phase,
    output logic [METER_W-1:0]         meter_level,
    output logic                       meter_valid
);

    import audio_fx_pkg::*;

    localparam int BUS_W = CHANNELS * DATA_W;

    // Valid state: handshake FSM and its registered strobes.
    state_t               state_q, state_d;
    logic                 read_q, read_d;
    logic                 write_q, write_d;
    logic                 mv_q, mv_d;
    // Captured at READ so config changes elsewhere cannot disturb the sample.
    logic [BUS_W-1:0]     in_q, in_d;
    logic [1:0]           mode_q, mode_d;
    logic                 cphase_q, cphase_d;
    logic [BUS_W-1:0]     out_q, out_d;
    logic [METER_W-1:0]   meter_q, meter_d;

    logic                 phase_w;
    logic [BUS_W-1:0]     proc_out;
    logic [CHANNELS*METER_W-1:0] abs_flat;
    logic [METER_W-1:0]   meter_max;

    gate_divider #(
        .DIV_W(DIV_W)
    ) u_div (
        .clk       (CLOCK_50),
        .rst       (reset),
        .cfg_period(cfg_period),
        .gate_phase(phase_w)
    );

    // Per-channel gate arithmetic and magnitude for the meter.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic signed [DATA_W-1:0]  s_in;
        logic signed [DATA_W-1:0]  s_out;
        logic signed [METER_W-1:0] s_top;

        assign s_in = in_q[c*DATA_W +: DATA_W];

        always_comb begin
            s_out = s_in;
            case (mode_q)
                MODE_BYPASS:  s_out = s_in;
                MODE_GATE:    s_out = cphase_q ? '0 : s_in;
                MODE_ATTEN:   s_out = cphase_q ? (s_in >>> ATTEN_SHIFT) : s_in;
                MODE_INVGATE: s_out = cphase_q ? s_in : '0;
                default:      s_out = s_in;
            endcase
        end

        assign proc_out[c*DATA_W +: DATA_W] = s_out;
        assign s_top = s_out[DATA_W-1 -: METER_W];

        // The most negative value has no positive twin; clamp it to full scale.
        always_comb begin
            if (s_top == {1'b1, {(METER_W-1){1'b0}}})
                abs_flat[c*METER_W +: METER_W] = {1'b0, {(METER_W-1){1'b1}}};
            else if (s_top[METER_W-1])
                abs_flat[c*METER_W +: METER_W] = -s_top;
            else
                abs_flat[c*METER_W +: METER_W] = s_top;
        end
    end

    always_comb begin
        meter_max = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (abs_flat[c*METER_W +: METER_W] > meter_max)
                meter_max = abs_flat[c*METER_W +: METER_W];
        end
    end

    // Strobes are decided one cycle ahead so they leave the block registered:
    // the write decision taken in PROC (or while waiting in WRITE) lands in WRITE.
    // proc_out depends only on captured state, so meter_max is stable from PROC on.
    always_comb begin
        state_d  = state_q;
        read_d   = 1'b0;
        write_d  = 1'b0;
        mv_d     = 1'b0;
        in_d     = in_q;
        mode_d   = mode_q;
        cphase_d = cphase_q;
        out_d    = out_q;
        meter_d  = meter_q;
        case (state_q)
            st_idle: begin
                if (audio_in_available && audio_out_allowed) begin
                    state_d = st_read;
                    read_d  = 1'b1;
                end
            end
            st_read: begin
                in_d     = audio_in_data;
                mode_d   = cfg_mode;
                cphase_d = phase_w;
                state_d  = st_proc;
            end
            st_proc: begin
                out_d   = proc_out;
                state_d = st_write;
                if (audio_out_allowed) begin
                    write_d = 1'b1;
                    mv_d    = 1'b1;
                    meter_d = meter_max;
                end
            end
            st_write: begin
                if (write_q) begin
                    state_d = st_idle;
                end else if (audio_out_allowed) begin
                    write_d = 1'b1;
                    mv_d    = 1'b1;
                    meter_d = meter_max;
                end
            end
            default: state_d = st_idle;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= st_idle;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            mv_q     <= 1'b0;
            in_q     <= '0;
            mode_q   <= MODE_BYPASS;
            cphase_q <= 1'b0;
            out_q    <= '0;
            meter_q  <= '0;
        end else begin
            state_q  <= state_d;
            read_q   <= read_d;
            write_q  <= write_d;
            mv_q     <= mv_d;
            in_q     <= in_d;
            mode_q   <= mode_d;
            cphase_q <= cphase_d;
            out_q    <= out_d;
            meter_q  <= meter_d;
        end
    end

    assign read_audio_in   = read_q;
    assign write_audio_out = write_q;
    assign meter_valid     = mv_q;
    assign audio_out_data  = out_q;
    assign meter_level     = meter_q;
    assign gate_phase      = phase_w;

endmodule

// File: tb/tb_audio_gate_fx.sv
// Directed bench for audio_gate_fx: divider vector table, fixed-latency
// transactions checked through an expected-value queue, backpressure and
// mid-transaction reset sequences.
module tb_audio_gate_fx;

    import audio_fx_pkg::*;

    localparam int SB_W = 80;

    logic         clk;
    logic         reset;
    logic [17:0]  cfg_period;
    logic [1:0]   cfg_mode;
    logic         audio_in_available;
    logic [63:0]  audio_in_data;
    logic         read_audio_in;
    logic         audio_out_allowed;
    logic [63:0]  audio_out_data;
    logic         write_audio_out;
    logic         gate_phase;
    logic [15:0]  meter_level;
    logic         meter_valid;

    int n_vec;
    int n_bad;

    logic [SB_W-1:0] exp_q[$];

    audio_gate_fx dut (
        .CLOCK_50          (clk),
        .reset             (reset),
        .cfg_period        (cfg_period),
        .cfg_mode          (cfg_mode),
        .audio_in_available(audio_in_available),
        .audio_in_data     (audio_in_data),
        .read_audio_in     (read_audio_in),
        .audio_out_allowed (audio_out_allowed),
        .audio_out_data    (audio_out_data),
        .write_audio_out   (write_audio_out),
        .gate_phase        (gate_phase),
        .meter_level       (meter_level),
        .meter_valid       (meter_valid)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] all_outs();
        return {12'd0, audio_out_data, read_audio_in, write_audio_out,
                gate_phase, meter_valid, meter_level};
    endfunction

    // Scoreboard: every push strobe must match the oldest expected {data, meter}.
    always @(negedge clk) begin
        if (write_audio_out) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_write: got data %0h with no expected entry", audio_out_data);
            end else begin
                logic [SB_W-1:0] e;
                e = exp_q.pop_front();
                chk("sb_data_meter", {16'd0, audio_out_data, meter_level}, {16'd0, e});
                chk("sb_meter_valid", 96'(meter_valid), 96'd1);
            end
        end
    end

    // Driver: one full transaction from IDLE, checking the strobe timing.
    task automatic txn(input logic [63:0] din, input logic [1:0] mode,
                       input logic [63:0] dexp, input logic [15:0] mexp);
        exp_q.push_back({dexp, mexp});
        audio_in_data      = din;
        cfg_mode           = mode;
        audio_in_available = 1'b1;
        audio_out_allowed  = 1'b1;
        @(negedge clk);                           // READ
        chk("read_latency", 96'(read_audio_in), 96'd1);
        audio_in_available = 1'b0;
        @(negedge clk);                           // PROC
        chk("proc_strobes", 96'({read_audio_in, write_audio_out}), 96'd0);
        cfg_mode      = ~mode;                    // must not affect the captured sample
        audio_in_data = ~din;
        @(negedge clk);                           // WRITE
        chk("write_latency", 96'(write_audio_out), 96'd1);
        @(negedge clk);                           // back to IDLE
        chk("write_pulse_end", 96'({write_audio_out, meter_valid, read_audio_in}), 96'd0);
        chk("data_hold", 96'(audio_out_data), 96'(dexp));
    endtask

    typedef struct {
        logic [17:0] period;
        logic        exp_phase;
    } div_vec_t;

    div_vec_t dv[17];

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset              = 1'b1;
        cfg_period         = '0;
        cfg_mode           = '0;
        audio_in_available = 1'b0;
        audio_in_data      = '0;
        audio_out_allowed  = 1'b0;

        // Divider vectors: period 3 toggles every 4 clocks; dropping to 1 while
        // the count is 3 wraps on the next edge, then toggles every 2.
        dv[0]  = '{18'd3, 1'b0}; dv[1]  = '{18'd3, 1'b0}; dv[2]  = '{18'd3, 1'b0};
        dv[3]  = '{18'd3, 1'b1}; dv[4]  = '{18'd3, 1'b1}; dv[5]  = '{18'd3, 1'b1};
        dv[6]  = '{18'd3, 1'b1}; dv[7]  = '{18'd3, 1'b0}; dv[8]  = '{18'd3, 1'b0};
        dv[9]  = '{18'd3, 1'b0}; dv[10] = '{18'd3, 1'b0};
        dv[11] = '{18'd1, 1'b1}; dv[12] = '{18'd1, 1'b1}; dv[13] = '{18'd1, 1'b0};
        dv[14] = '{18'd1, 1'b0}; dv[15] = '{18'd1, 1'b1};
        dv[16] = '{18'd0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), 96'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_outputs", all_outs(), 96'd0);
        end

        // Divider table
        for (int i = 0; i < 17; i++) begin
            cfg_period = dv[i].period;
            @(negedge clk);
            chk($sformatf("div_phase_%0d", i), 96'(gate_phase), 96'(dv[i].exp_phase));
        end

        // Bypass, phase 0: output equals input, most negative top half saturates
        txn({32'h8000_0000, 32'h1234_5678}, MODE_BYPASS,
            {32'h8000_0000, 32'h1234_5678}, 16'h7FFF);
        // Attenuate with phase 0 passes through
        txn({32'hFFFF_FFF0, 32'h0000_0100}, MODE_ATTEN,
            {32'hFFFF_FFF0, 32'h0000_0100}, 16'h0001);
        // Inverted gate with phase 0 mutes
        txn({32'h4000_0000, 32'hA000_0000}, MODE_INVGATE, 64'd0, 16'h0000);

        // Bring the phase to 1 and hold it there for the next transactions
        cfg_period = 18'd20;
        repeat (21) @(negedge clk);
        chk("phase_high", 96'(gate_phase), 96'd1);
        txn({32'hFFFF_FFF0, 32'h0000_0100}, MODE_ATTEN,
            {32'hFFFF_FFFC, 32'h0000_0040}, 16'h0001);
        txn({32'h4000_0000, 32'hA000_0000}, MODE_GATE, 64'd0, 16'h0000);
        txn({32'h4000_0000, 32'hA000_0000}, MODE_INVGATE,
            {32'h4000_0000, 32'hA000_0000}, 16'h6000);
        cfg_period = '0;
        @(negedge clk);
        chk("phase_cleared", 96'(gate_phase), 96'd0);

        // Backpressure: allowed low through PROC and four WRITE cycles
        exp_q.push_back({32'h0001_0000, 32'hFFFE_0000, 16'h0002});
        audio_in_data      = {32'h0001_0000, 32'hFFFE_0000};
        cfg_mode           = MODE_BYPASS;
        audio_in_available = 1'b1;
        audio_out_allowed  = 1'b1;
        @(negedge clk);                           // READ
        chk("bp_read", 96'(read_audio_in), 96'd1);
        audio_out_allowed = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_stall", 96'({read_audio_in, write_audio_out, meter_valid}), 96'd0);
        end
        chk("bp_in_write", 96'(dut.state_q), 96'(st_write));
        audio_out_allowed = 1'b1;
        @(negedge clk);
        chk("bp_write", 96'({read_audio_in, write_audio_out}), 96'd1);
        audio_in_available = 1'b0;
        @(negedge clk);
        chk("bp_single", 96'({read_audio_in, write_audio_out}), 96'd0);

        // Reset during PROC: sample dropped, outputs clear at once
        audio_in_data      = {32'h1111_0000, 32'h2222_0000};
        audio_in_available = 1'b1;
        @(negedge clk);                           // READ
        chk("rst_read", 96'(read_audio_in), 96'd1);
        audio_in_available = 1'b0;
        @(posedge clk);                           // entering PROC
        #2 reset = 1'b1;
        #1 chk("rst_async_clear", all_outs(), 96'd0);
        chk("rst_state_idle", 96'(dut.state_q), 96'(st_idle));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_write", 96'({read_audio_in, write_audio_out}), 96'd0);
        end
        txn({32'hFFFF_0000, 32'h0003_0000}, MODE_BYPASS,
            {32'hFFFF_0000, 32'h0003_0000}, 16'h0003);

        repeat (2) @(negedge clk);
        chk("sb_drained", 96'(exp_q.size()), 96'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, expected completion before 200000");
        $fatal(1);
    end

endmodule

// File: doc/audio_gate_fx.md
Name: audio_gate_fx

Overview:
- Parametrised audio chopper/gate placed between the Audio_Controller input FIFO and output FIFO.
- Generalises the switch-driven square-wave mute:
  - N channels of configurable width.
  - Four gate modes, including attenuate and inverted gate.
  - An explicit registered read/write handshake FSM instead of combinational strobes.
  - A per-sample peak-level meter for LED display.

Parameters:
- DATA_W, 32, bits per channel sample (two's complement).
- CHANNELS, 2, channel count; channel 0 occupies the LSBs of the packed buses.
- DIV_W, 18, width of gate half-period counter.
- ATTEN_SHIFT, 2, arithmetic right shift applied in attenuate mode.
- METER_W, 16, meter width; taken from the top METER_W bits of each sample.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_period  in  DIV_W  gate half-period in clocks, minus 1; 0 = gate disabled.
- cfg_mode  in  2  0 bypass, 1 gate (mute when phase=1), 2 attenuate when phase=1, 3 inverted gate (mute when phase=0).
- audio_in_available  in  1  input FIFO holds a sample set.
- audio_in_data  in  CHANNELS*DATA_W  input samples; valid while available.
- read_audio_in  out  1  one-cycle pop strobe to the input FIFO.
- audio_out_allowed  in  1  output FIFO has space.
- audio_out_data  out  CHANNELS*DATA_W  processed samples.
- write_audio_out  out  1  one-cycle push strobe to the output FIFO.
- gate_phase  out  1  current gate phase.
- meter_level  out  METER_W  max |sample| over channels of the last written set.
- meter_valid  out  1  one-cycle pulse when meter_level updates.

Behaviour:
- Reset (asynchronous, immediate): FSM returns to IDLE, divider count 0, and every output is 0. This includes audio_out_data, gate_phase and meter_level.
- Reset mid-transaction discards the in-flight sample. A pop already issued is not replayed.
- Divider:
  - When count >= cfg_period: count goes to 0 and gate_phase toggles.
  - Otherwise count increments.
  - The >= compare means that if cfg_period is lowered below the current count, the divider wraps on the next cycle.
  - cfg_period==0: count is held at 0 and gate_phase is forced to 0.
- FSM states IDLE, READ, PROC, WRITE. All strobes are registered outputs.
  - IDLE: if audio_in_available && audio_out_allowed, go to READ.
  - READ: read_audio_in=1 for exactly this cycle. Capture audio_in_data, cfg_mode and gate_phase. Go to PROC.
  - PROC: compute each channel into the output register. Go to WRITE.
  - WRITE:
    - If audio_out_allowed: write_audio_out=1 for this cycle, meter_valid=1 with updated meter_level, then go to IDLE.
    - Otherwise hold in WRITE with write low until allowed.
- Latency: READ strobe 1 cycle after the qualifying IDLE cycle; WRITE strobe 2 cycles after READ. Minimum spacing between transactions is 4 cycles.
- Per-channel arithmetic, using the captured mode m and captured phase p:
  - m=0: out = in.
  - m=1: out = p ? 0 : in.
  - m=2: out = p ? (in >>> ATTEN_SHIFT) : in. The shift is sign-preserving, so -1 stays -1.
  - m=3: out = p ? in : 0.
- Meter: per channel s = out[DATA_W-1 -: METER_W], a = |s|. The most negative value saturates to 2^(METER_W-1)-1. meter_level = max over channels of a, registered on the WRITE-strobe cycle.
- Config changes outside READ do not affect the in-flight sample.
- audio_out_data holds its value between writes.

Decomposition:
- Package audio_fx_pkg holds:
  - Mode constants MODE_BYPASS=0, MODE_GATE=1, MODE_ATTEN=2, MODE_INVGATE=3.
  - FSM state enum st_idle/st_read/st_proc/st_write.
- One natural sub-module: gate_divider, containing the counter plus phase toggle, with cfg_period in and gate_phase out.
- The channel loop is a generate loop inside audio_gate_fx.

Test Plan:
- Reset at time 0, then release, with available=0: every output stays 0; gate_phase stays 0 while cfg_period=0.
- cfg_period=3: gate_phase toggles every 4 clocks. Then change cfg_period to 1 while count=3: wrap occurs the next cycle, then toggles every 2 clocks.
- mode=0, available=allowed=1 constantly, in = {32'h8000_0000, 32'h1234_5678}:
  - read strobe 1 cycle after IDLE, write strobe 2 cycles later, output equal to input.
  - meter_level = 16'h7FFF (saturated).
- mode=2, phase captured =1, in = {32'hFFFF_FFF0, 32'h0000_0100}: out = {32'hFFFF_FFFC, 32'h0000_0040}.
- mode=1 with phase=1 gives 0; mode=3 with phase=1 gives in unchanged.
- Hold allowed=0 from the PROC cycle for 5 clocks: write stays low, FSM sits in WRITE; a single write strobe follows allowed rising, with no second read.
- Assert reset during the PROC cycle: no write strobe occurs; outputs clear to 0 asynchronously; the next transaction proceeds normally.
